// File: rtl/genius_control.sv
// ============================================================================
//  Module   : genius_control
//  Purpose  : Moore control FSM for the Genius game, driving the datapath
//             controls (R1, R2, E1..E4, SEL) from the datapath status flags
//             and two push-buttons (KEY[0]=enter, KEY[1]=start).
//  Option   : KEY_DEBOUNCE_EN -- when defined, a key must be stable for
//             DEB_CYCLES cycles to produce or re-arm a press event.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module genius_control #(
  parameter int p_key      = 4,
  parameter int DEB_CYCLES = 500000
) (
  input  logic             CLOCK_50,
  input  logic             R,
  input  logic [p_key-1:0] KEY,
  input  logic             end_FPGA,
  input  logic             end_User,
  input  logic             end_time,
  input  logic             win,
  input  logic             match,
  output logic             R1,
  output logic             R2,
  output logic             E1,
  output logic             E2,
  output logic             E3,
  output logic             E4,
  output logic             SEL
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_SETUP  = 3'd1,
    S_PLAY   = 3'd2,
    S_USER   = 3'd3,
    S_CHECK  = 3'd4,
    S_NEXT   = 3'd5,
    S_RESULT = 3'd6
  } state_t;

  // Output order: {R1, R2, E1, E2, E3, E4, SEL}
  localparam logic [6:0] c_outs_init = 7'b1100000;

  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_flush;
  logic       w_flushed;
  logic [1:0] w_press;
  logic       w_enter;
  logic       w_start;
  logic       w_unused;
  state_t     r_state;
  state_t     w_next;

  always_ff @(posedge CLOCK_50 or negedge R) begin
    if (!R) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_flush <= 2'b00;
    end else begin
      r_sync1 <= KEY[1:0];
      r_sync2 <= r_sync1;
      r_flush <= {r_flush[0], 1'b1};
    end
  end

  // The synchronizer holds reset values for two cycles after release; a key
  // may only arm once the real pin level has reached r_sync2.
  assign w_flushed = r_flush[1];

  genvar gk;
  generate
    for (gk = 0; gk < 2; gk++) begin : g_key
`ifdef KEY_DEBOUNCE_EN
      localparam int c_cw = $clog2(DEB_CYCLES + 1);
      localparam logic [c_cw-1:0] c_last = c_cw'(DEB_CYCLES - 1);
      logic [c_cw-1:0] r_cnt;
      logic            r_armed;
      logic            r_press;

      always_ff @(posedge CLOCK_50 or negedge R) begin
        if (!R) begin
          r_cnt   <= '0;
          r_armed <= 1'b0;
          r_press <= 1'b0;
        end else begin
          r_press <= 1'b0;
          if (!w_flushed) begin
            r_cnt <= '0;
          end else if (r_armed) begin
            if (!r_sync2[gk]) begin
              if (r_cnt == c_last) begin
                r_cnt   <= '0;
                r_armed <= 1'b0;
                r_press <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_cnt <= '0;
            end
          end else begin
            if (r_sync2[gk]) begin
              if (r_cnt == c_last) begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_cnt <= '0;
            end
          end
        end
      end

      assign w_press[gk] = r_press;
`else
      logic r_rel;
      logic r_press;

      always_ff @(posedge CLOCK_50 or negedge R) begin
        if (!R) begin
          r_rel   <= 1'b0;
          r_press <= 1'b0;
        end else begin
          r_press <= r_rel & ~r_sync2[gk];
          if (r_rel && !r_sync2[gk]) begin
            r_rel <= 1'b0;
          end else if (w_flushed && r_sync2[gk]) begin
            r_rel <= 1'b1;
          end
        end
      end

      assign w_press[gk] = r_press;
`endif
    end
  endgenerate

`ifdef KEY_DEBOUNCE_EN
  assign w_unused = &{1'b0, KEY[p_key-1:2]};
`else
  localparam logic [31:0] c_deb = DEB_CYCLES;
  assign w_unused = &{1'b0, KEY[p_key-1:2], c_deb};
`endif

  assign w_enter = w_press[0];
  assign w_start = w_press[1];

  always_comb begin
    w_next = S_INIT;
    case (r_state)
      S_INIT:   w_next = w_start  ? S_SETUP : S_INIT;
      S_SETUP:  w_next = w_enter  ? S_PLAY  : S_SETUP;
      S_PLAY:   w_next = end_FPGA ? S_USER  : S_PLAY;
      S_USER: begin
        if (end_User)      w_next = S_CHECK;
        else if (end_time) w_next = S_RESULT;
        else               w_next = S_USER;
      end
      S_CHECK:  w_next = (match && !win) ? S_NEXT : S_RESULT;
      S_NEXT:   w_next = S_PLAY;
      S_RESULT: w_next = w_start  ? S_INIT  : S_RESULT;
      default:  w_next = S_INIT;
    endcase
  end

  function automatic logic [6:0] f_outs(input state_t s);
    case (s)
      S_INIT:   f_outs = 7'b1100000;
      S_SETUP:  f_outs = 7'b0110000;
      S_PLAY:   f_outs = 7'b0100100;
      S_USER:   f_outs = 7'b0001010;
      S_CHECK:  f_outs = 7'b0100000;
      S_NEXT:   f_outs = 7'b0110000;
      S_RESULT: f_outs = 7'b0100001;
      default:  f_outs = 7'b1100000;
    endcase
  endfunction

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge CLOCK_50 or negedge R) begin
    if (!R) begin
      r_state                       <= S_INIT;
      {R1, R2, E1, E2, E3, E4, SEL} <= c_outs_init;
    end else begin
      r_state                       <= w_next;
      {R1, R2, E1, E2, E3, E4, SEL} <= f_outs(w_next);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_genius_control.sv
// ============================================================================
//  Module   : tb_genius_control
//  Purpose  : Scoreboard bench for genius_control; expected output vectors
//             are queued by the stimulus and consumed on every output change.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_genius_control;

  localparam logic [6:0] c_init   = 7'b1100000;
  localparam logic [6:0] c_setup  = 7'b0110000;
  localparam logic [6:0] c_play   = 7'b0100100;
  localparam logic [6:0] c_user   = 7'b0001010;
  localparam logic [6:0] c_check  = 7'b0100000;
  localparam logic [6:0] c_next   = 7'b0110000;
  localparam logic [6:0] c_result = 7'b0100001;

`ifdef KEY_DEBOUNCE_EN
  localparam int c_hold = 6;
`else
  localparam int c_hold = 1;
`endif

  typedef struct {
    logic [6:0] v;
    int         len;
    string      name;
  } exp_t;

  logic       CLOCK_50 = 1'b0;
  logic       R        = 1'b0;
  logic [3:0] KEY      = 4'hF;
  logic       end_FPGA = 1'b0;
  logic       end_User = 1'b0;
  logic       end_time = 1'b0;
  logic       win      = 1'b0;
  logic       match    = 1'b0;
  logic       R1, R2, E1, E2, E3, E4, SEL;
  logic [6:0] w_outs;

  exp_t q_exp[$];
  int   n_pass  = 0;
  int   n_total = 0;

  genius_control #(
    .p_key      (4),
    .DEB_CYCLES (4)
  ) u_dut (
    .CLOCK_50 (CLOCK_50),
    .R        (R),
    .KEY      (KEY),
    .end_FPGA (end_FPGA),
    .end_User (end_User),
    .end_time (end_time),
    .win      (win),
    .match    (match),
    .R1       (R1),
    .R2       (R2),
    .E1       (E1),
    .E2       (E2),
    .E3       (E3),
    .E4       (E4),
    .SEL      (SEL)
  );

  assign w_outs = {R1, R2, E1, E2, E3, E4, SEL};

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push(input logic [6:0] v, input int len, input string name);
    exp_t e;
    e.v = v; e.len = len; e.name = name;
    q_exp.push_back(e);
  endtask

  task automatic press(input int k);
    KEY[k] = 1'b0;
    tick(c_hold);
    KEY[k] = 1'b1;
    tick(12);
  endtask

  task automatic pulse_fpga();
    end_FPGA = 1'b1; tick(1); end_FPGA = 1'b0; tick(6);
  endtask

  task automatic pulse_user();
    end_User = 1'b1; tick(1); end_User = 1'b0; tick(6);
  endtask

  task automatic to_user();
    push(c_setup, 0, "init->setup"); press(1);
    push(c_play,  0, "setup->play"); press(0);
    push(c_user,  0, "play->user");  pulse_fpga();
  endtask

  // Monitor: every change of the output vector must match the queue head;
  // entries with a nonzero len must also persist for exactly len cycles.
  initial begin
    logic [6:0] prev;
    exp_t e, pe;
    bit   have_pe;
    int   cyc, last_chg;
    cyc = 0; last_chg = 0; have_pe = 1'b0;
    wait (R === 1'b1);
    @(negedge CLOCK_50);
    prev = w_outs;
    n_total++;
    if (q_exp.size() == 0) begin
      $display("FAIL reset: queue empty, outputs %b", w_outs);
    end else begin
      e = q_exp.pop_front();
      if (w_outs === e.v) n_pass++;
      else $display("FAIL %s: got %b expected %b", e.name, w_outs, e.v);
      pe = e; have_pe = 1'b1;
    end
    forever begin
      @(negedge CLOCK_50);
      cyc++;
      if (w_outs !== prev) begin
        if (have_pe && pe.len != 0) begin
          n_total++;
          if (cyc - last_chg == pe.len) n_pass++;
          else $display("FAIL %s_len: lasted %0d cycles expected %0d",
                        pe.name, cyc - last_chg, pe.len);
        end
        n_total++;
        if (q_exp.size() == 0) begin
          $display("FAIL unexpected_change: got %b after %b, nothing expected",
                   w_outs, prev);
          have_pe = 1'b0;
        end else begin
          e = q_exp.pop_front();
          if (w_outs === e.v) n_pass++;
          else $display("FAIL %s: got %b expected %b", e.name, w_outs, e.v);
          pe = e; have_pe = 1'b1;
        end
        last_chg = cyc;
        prev = w_outs;
      end
    end
  end

  initial begin
    push(c_init, 0, "reset");
    tick(3);
    R = 1'b1;
    tick(8);

    // Full round with continuation into the next round
    to_user();
    match = 1'b1; win = 1'b0;
    push(c_check, 1, "user->check");
    push(c_next,  1, "check->next");
    push(c_play,  0, "next->play");
    pulse_user();
    match = 1'b0;

    // Keys and stale flags ignored in PLAY
    press(0);
    press(1);
    end_User = 1'b1; end_time = 1'b1; tick(4);
    end_User = 1'b0; end_time = 1'b0; tick(2);

    push(c_user, 0, "play->user2"); pulse_fpga();
    press(0);

    // Timeout
    push(c_result, 0, "user->result_timeout");
    end_time = 1'b1; tick(1); end_time = 1'b0; tick(6);
    press(0);
    end_FPGA = 1'b1; tick(3); end_FPGA = 1'b0;
    push(c_init, 0, "result->init"); press(1);

`ifdef KEY_DEBOUNCE_EN
    KEY[1] = 1'b0; tick(1); KEY[1] = 1'b1; tick(1);
    KEY[1] = 1'b0; tick(1); KEY[1] = 1'b1; tick(12);
`endif
    push(c_setup, 0, "init->setup_deb"); press(1);
    press(1);
    push(c_play, 0, "setup->play2"); press(0);
    push(c_user, 0, "play->user3"); pulse_fpga();

    // end_User and end_time together, sequence mismatch -> lose
    match = 1'b0; win = 1'b0;
    push(c_check,  1, "both_flags->check");
    push(c_result, 0, "check->result_lose");
    end_User = 1'b1; end_time = 1'b1; tick(1);
    end_User = 1'b0; end_time = 1'b0; tick(6);

    push(c_init, 0, "result->init2"); press(1);

    // Winning final round
    to_user();
    match = 1'b1; win = 1'b1;
    push(c_check,  1, "user->check_win");
    push(c_result, 0, "check->result_win");
    pulse_user();
    match = 1'b0; win = 1'b0;
    push(c_init, 0, "result->init3"); press(1);

    // Asynchronous reset mid-USER with start held through release
    to_user();
    push(c_init, 0, "async_reset_user");
    R = 1'b0;
    KEY[1] = 1'b0;
    tick(2);
    R = 1'b1;
    tick(12);
    KEY[1] = 1'b1;
    tick(12);
    push(c_setup, 0, "init->setup_after_reset"); press(1);

    tick(10);
    n_total++;
    if (q_exp.size() == 0) n_pass++;
    else $display("FAIL queue_drain: %0d entries left, expected 0", q_exp.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
